// File: rtl/shift_unit_ctrl.sv
// Two-stage control wrapper around an external 32-bit rotate-left shifter.
// Stage 1 drives the shifter; stage 2 registers the masked/sign-filled result.
module shift_unit_ctrl (
   input  logic        CLK,
   input  logic        N_RST,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [31:0] IN_DATA,
   input  logic [4:0]  IN_AMT,
   input  logic [1:0]  IN_OP,
   input  logic [3:0]  IN_TAG,
   output logic [31:0] ROT_IN,
   output logic [4:0]  ROT_AMT,
   input  logic [31:0] ROT_OUT,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] OUT_DATA,
   output logic [3:0]  OUT_TAG
);

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROL = 2'b11
   } op_e;

   logic        s1_valid;
   logic [4:0]  s1_n;
   op_e         s1_op;
   logic [3:0]  s1_tag;
   logic        s1_sign;

   logic        accept;
   logic        advance;
   logic        emit;
   logic [31:0] mask;
   logic [31:0] result;
   op_e         in_op;

   assign in_op    = op_e'(IN_OP);
   assign IN_READY = ~s1_valid | ~OUT_VALID | OUT_READY;
   assign accept   = IN_VALID & IN_READY;
   assign advance  = s1_valid & (~OUT_VALID | OUT_READY);
   assign emit     = OUT_VALID & OUT_READY;

   // Right shifts are rotate-left by (32-n) followed by masking off the wrapped bits.
   always_comb begin
      mask   = 32'hFFFF_FFFF;
      result = ROT_OUT;
      case (s1_op)
         OP_SLL: begin
            mask   = 32'hFFFF_FFFF << s1_n;
            result = ROT_OUT & mask;
         end
         OP_SRL: begin
            mask   = 32'hFFFF_FFFF >> s1_n;
            result = ROT_OUT & mask;
         end
         OP_SRA: begin
            mask   = 32'hFFFF_FFFF >> s1_n;
            result = (ROT_OUT & mask) | (s1_sign ? ~mask : '0);
         end
         default: result = ROT_OUT;
      endcase
   end

   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         s1_valid  <= 1'b0;
         s1_n      <= '0;
         s1_op     <= OP_SLL;
         s1_tag    <= '0;
         s1_sign   <= 1'b0;
         ROT_IN    <= '0;
         ROT_AMT   <= '0;
         OUT_VALID <= 1'b0;
         OUT_DATA  <= '0;
         OUT_TAG   <= '0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_n     <= IN_AMT;
            s1_op    <= in_op;
            s1_tag   <= IN_TAG;
            s1_sign  <= IN_DATA[31];
            ROT_IN   <= IN_DATA;
            ROT_AMT  <= (in_op == OP_SRL || in_op == OP_SRA) ? (~IN_AMT + 5'd1) : IN_AMT;
         end else if (advance) begin
            s1_valid <= 1'b0;
         end

         if (advance) begin
            OUT_VALID <= 1'b1;
            OUT_DATA  <= result;
            OUT_TAG   <= s1_tag;
         end else if (emit) begin
            OUT_VALID <= 1'b0;
         end
      end
   end

endmodule

// File: doc/shift_unit_ctrl.md
Name: shift_unit_ctrl

Overview:
- Pipelined control wrapper around the 32-bit rotate-left shifter datapath.
- Accepts shift operations over a valid/ready handshake and drives the shifter's data and amount inputs from a stage-1 register.
- Consumes the shifter's rotated output and applies masking and sign fill to realise SLL/SRL/SRA/ROL.
- Registers the result in stage 2 for the ALU writeback path.

Parameters:
- None. Datapath is fixed at 32 bits; amount field is fixed at 5 bits.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- N_RST  input  1  asynchronous active-low reset.
- IN_VALID  input  1  operation offered.
- IN_READY  output  1  operation accepted this cycle when high with IN_VALID.
- IN_DATA  input  32  operand.
- IN_AMT  input  5  shift amount n.
- IN_OP  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- IN_TAG  input  4  opaque tag, returned with the result.
- ROT_IN  output  32  data to shifter IN.
- ROT_AMT  output  5  rotate-left amount to shifter SHFT.
- ROT_OUT  input  32  shifter OUT (combinational from ROT_IN/ROT_AMT).
- OUT_VALID  output  1  result available.
- OUT_READY  input  1  consumer takes result.
- OUT_DATA  output  32  shifted result.
- OUT_TAG  output  4  tag of result.

Behaviour:
- Reset (N_RST low, asynchronous):
  - s1_valid=0, s2_valid=0, OUT_VALID=0, OUT_DATA=0, OUT_TAG=0, ROT_IN=0, ROT_AMT=0.
  - IN_READY=1 once reset releases (stage 1 is empty).
- Handshakes:
  - Accept = IN_VALID & IN_READY.
  - Emit = OUT_VALID & OUT_READY.
  - IN_VALID may drop without a transfer; no combinational path from IN_VALID to IN_READY.
- Stage 1, on accept, registers:
  - ROT_IN = IN_DATA.
  - ROT_AMT = IN_AMT for SLL and ROL; (32-IN_AMT) mod 32, i.e. (~IN_AMT+1)&5'h1F, for SRL and SRA.
  - n = IN_AMT, OP, TAG, sign = IN_DATA[31].
  - s1_valid = 1.
- Stage 2, on advance, registers mask/fill applied to ROT_OUT:
  - SLL: mask = 32'hFFFFFFFF << n; result = ROT_OUT & mask.
  - SRL: mask = 32'hFFFFFFFF >> n; result = ROT_OUT & mask.
  - SRA: as SRL, then OR with ~mask if sign=1.
  - ROL: result = ROT_OUT.
  - n=0 for every op: result = operand unchanged (mask is all ones, rotate amount 0).
- Advance = s1_valid & (~s2_valid | OUT_READY).
  - On advance: s2 captures the result and tag, s2_valid = 1.
  - If not advancing and Emit: s2_valid = 0.
- IN_READY = ~s1_valid | (~s2_valid | OUT_READY).
  - Depends on OUT_READY combinationally; this is the only combinational in-to-out path.
  - On accept without advance, s1 is empty by definition. On accept with advance, s1 is reloaded the same cycle.
  - If advance occurs with no accept: s1_valid = 0.
- Latency: accept in cycle t gives OUT_VALID in cycle t+2 if unstalled. Throughput: 1 op/cycle.
- Stall: while OUT_VALID & ~OUT_READY, OUT_DATA and OUT_TAG hold stable.
  - s1 holds, and ROT_IN/ROT_AMT stay constant.
  - IN_READY=0 when both stages are full.
- Ordering: results emerge in acceptance order; no drop, no duplication.
- Reset mid-operation: all in-flight ops are discarded; no OUT_VALID in the cycle after release.
- IN_DATA/IN_AMT/IN_OP values are don't-care when IN_VALID=0; ROT_* change only on accept.

Test Plan:
- SLL 0x80000001, n=4 -> ROT_AMT=4; OUT_DATA=0x00000010 two cycles after accept; OUT_TAG matches.
- SRA 0x80000000, n=31 -> ROT_AMT=1, OUT_DATA=0xFFFFFFFF. SRL same operand -> 0x00000001. ROL 0x80000001, n=1 -> 0x00000003.
- n=0 for all four ops with operand 0xDEADBEEF -> OUT_DATA=0xDEADBEEF each; ROT_AMT=0 including SRL/SRA.
- Back-to-back 8 ops, OUT_READY=1 -> IN_READY stays 1; one result per cycle, in order with tags 0..7.
- Hold OUT_READY=0 after 3 offered ops -> two accepted, IN_READY=0, OUT_DATA/OUT_TAG/ROT_IN stable; release -> remaining op drains, order kept.
- Assert N_RST low with both stages full -> OUT_VALID=0 immediately; after release IN_READY=1 and no stale result appears.
